obi_subordinate: RTL and testbench

- OBI subordinate (responder) that terminates OBI requests into a local word-addressed register array of DEPTH entries.
- Accepts A-channel requests with a combinational grant and performs the access on the handshake cycle.
- Returns responses in order through an RSP_DEPTH-entry response FIFO that honours rready backpressure.
- Serves as the bus endpoint and bench target for the team's OBI masters, and as a simple memory-mapped register block.

---
 rtl/obi_subordinate.sv | 126 ++++++++++++
 tb/tb_obi_subordinate.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/obi_subordinate.sv
// OBI subordinate: terminates OBI requests into a word-addressed register
// array and returns in-order responses through a small response FIFO.
module obi_subordinate #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           RSP_DEPTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    output logic [7:0]              err_cnt_o
);
    localparam int unsigned BW   = DATA_WIDTH / 8;
    localparam int unsigned OFFB = $clog2(BW);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam int unsigned PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] fdata_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fdata_d [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  ferr_q, ferr_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic [ADDR_WIDTH-1:0] off;
    logic [IW-1:0]         idx;
    logic                  dec_err;
    logic                  hs;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rsp_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Grant depends only on registered occupancy: no rready->gnt path.
    assign obi_gnt_o = obi_req_i && (cnt_q < CW'(RSP_DEPTH));
    assign hs        = obi_req_i && obi_gnt_o;
    assign pop       = rvalid_q && obi_rready_i;

    always_comb begin
        off     = obi_addr_i - BASE_ADDR;
        idx     = off[OFFB +: IW];
        dec_err = (obi_addr_i < BASE_ADDR)
               || ((off >> (OFFB + IW)) != '0)
               || ((off & ADDR_WIDTH'(BW - 1)) != '0);
        rsp_data = (obi_we_i || dec_err) ? '0 : mem_q[idx];
    end

    always_comb begin
        mem_d = mem_q;
        if (hs && obi_we_i && !dec_err) begin
            for (int i = 0; i < int'(BW); i++) begin
                if (obi_be_i[i]) mem_d[idx][8*i +: 8] = obi_wdata_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        fdata_d = fdata_q;
        ferr_d  = ferr_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (hs) begin
            fdata_d[wptr_q] = rsp_data;
            ferr_d[wptr_q]  = dec_err;
            wptr_d          = ptr_inc(wptr_q);
        end
        if (pop) rptr_d = ptr_inc(rptr_q);
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        rvalid_d  = (cnt_d != '0);
        err_cnt_d = err_cnt_q;
        if (pop && ferr_q[rptr_q] && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            for (int i = 0; i < int'(RSP_DEPTH); i++) fdata_q[i] <= '0;
            ferr_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            fdata_q   <= fdata_d;
            ferr_q    <= ferr_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rvalid_q ? fdata_q[rptr_q] : '0;
    assign obi_err_o    = rvalid_q && ferr_q[rptr_q];
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_obi_subordinate.sv
// Scoreboard bench for obi_subordinate: issuer pushes expected responses,
// a negedge monitor pops and compares them and tracks FIFO occupancy.
module tb_obi_subordinate;
    localparam int RD = 2;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        obi_req_i = 1'b0;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i = '0;
    logic        obi_we_i = 1'b0;
    logic [3:0]  obi_be_i = '0;
    logic [31:0] obi_wdata_i = '0;
    logic        obi_rvalid_o;
    logic        obi_rready_i = 1'b1;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic [7:0]  err_cnt_o;

    obi_subordinate #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH(16),
        .BASE_ADDR(32'h0),
        .RSP_DEPTH(RD)
    ) dut (
        .clk_i(clk_i),
        .reset_ni(reset_ni),
        .obi_req_i(obi_req_i),
        .obi_gnt_o(obi_gnt_o),
        .obi_addr_i(obi_addr_i),
        .obi_we_i(obi_we_i),
        .obi_be_i(obi_be_i),
        .obi_wdata_i(obi_wdata_i),
        .obi_rvalid_o(obi_rvalid_o),
        .obi_rready_i(obi_rready_i),
        .obi_rdata_o(obi_rdata_o),
        .obi_err_o(obi_err_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    rsp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   m_cnt = 0;
    int   cyc = 0;
    bit   done = 0;

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Idle bus carries junk that must be ignored without a handshake.
    task automatic idle_bus();
        obi_req_i   = 1'b0;
        obi_addr_i  = 32'h0;
        obi_we_i    = 1'b1;
        obi_be_i    = 4'hF;
        obi_wdata_i = 32'hBAD0BAD0;
    endtask

    // Monitor: occupancy model, grant rule, in-order response checking.
    always @(negedge clk_i) begin
        bit   hs;
        bit   pop;
        rsp_t r;
        if (reset_ni) begin
            check("rvalid", obi_rvalid_o, m_cnt != 0);
            check("gnt", obi_gnt_o, obi_req_i && (m_cnt < RD));
            hs  = obi_req_i && obi_gnt_o;
            pop = obi_rvalid_o && obi_rready_i;
            if (!obi_rvalid_o) check("idle_rsp", {obi_rdata_o, obi_err_o}, 33'h0);
            if (pop) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    r = sb.pop_front();
                    check("rdata", obi_rdata_o, r.d);
                    check("err", obi_err_o, r.e);
                end
            end
            m_cnt = m_cnt + int'(hs) - int'(pop);
        end
    end

    task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        int w = 0;
        sb.push_back(rsp_t'{d: ed, e: ee});
        obi_req_i   = 1'b1;
        obi_addr_i  = a;
        obi_we_i    = we;
        obi_be_i    = be;
        obi_wdata_i = wd;
        while (1) begin
            @(negedge clk_i);
            if (obi_gnt_o) break;
            w++;
            if (w > 100) begin
                fail_now("gnt_timeout");
                break;
            end
        end
        @(posedge clk_i);
        #1;
        idle_bus();
    endtask

    task automatic drain();
        int w = 0;
        obi_rready_i = 1'b1;
        while ((sb.size() != 0 || m_cnt != 0) && w < 100) begin
            @(posedge clk_i);
            #1;
            w++;
        end
        if (w >= 100) fail_now("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int w;
        idle_bus();
        reset_ni     = 1'b0;
        obi_rready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #3 reset_ni = 1'b1;
        @(negedge clk_i);
        check("rst_gnt", obi_gnt_o, 0);
        check("rst_rvalid", obi_rvalid_o, 0);
        check("rst_rdata", obi_rdata_o, 0);
        check("rst_errcnt", err_cnt_o, 0);
        @(posedge clk_i);
        #1;
        issue(32'h14, 0, 4'hF, 32'h0, 32'h0, 0);
        drain();

        issue(32'h14, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        issue(32'h14, 1, 4'b0010, 32'h00005500, 32'h0, 0);
        issue(32'h14, 0, 4'hF, 32'h0, 32'hDEAD55EF, 0);
        drain();

        issue(32'h00, 1, 4'hF, 32'h11111111, 32'h0, 0);
        issue(32'h04, 1, 4'hF, 32'h22222222, 32'h0, 0);
        issue(32'h08, 1, 4'hF, 32'h33333333, 32'h0, 0);
        drain();

        obi_rready_i = 1'b0;
        done = 0;
        fork
            begin
                issue(32'h00, 0, 4'hF, 32'h0, 32'h11111111, 0);
                issue(32'h04, 0, 4'hF, 32'h0, 32'h22222222, 0);
                issue(32'h08, 0, 4'hF, 32'h0, 32'h33333333, 0);
                done = 1;
            end
        join_none
        repeat (4) @(negedge clk_i);
        check("full_gnt_held", {obi_req_i, obi_gnt_o}, 2'b10);
        @(posedge clk_i);
        #1 obi_rready_i = 1'b1;
        w = 0;
        while (!done && w < 50) begin
            @(posedge clk_i);
            #1;
            w++;
        end
        if (!done) fail_now("bp_issue_timeout");
        drain();

        issue(32'h40, 0, 4'hF, 32'h0, 32'h0, 1);
        issue(32'h03, 1, 4'hF, 32'hFFFFFFFF, 32'h0, 1);
        issue(32'h00, 0, 4'hF, 32'h0, 32'h11111111, 0);
        issue(32'h3C, 1, 4'hF, 32'hCAFEF00D, 32'h0, 0);
        issue(32'h3C, 0, 4'hF, 32'h0, 32'hCAFEF00D, 0);
        drain();
        check("err_cnt", err_cnt_o, 2);

        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            issue(32'(i * 4), 1, 4'hF, 32'hA5000000 | 32'(i), 32'h0, 0);
        end
        check("tput_cycles", cyc - c0, 8);
        for (int i = 0; i < 8; i++) begin
            issue(32'(i * 4), 0, 4'hF, 32'h0, 32'hA5000000 | 32'(i), 0);
        end
        drain();

        obi_rready_i = 1'b0;
        issue(32'h14, 0, 4'hF, 32'h0, 32'hDEAD55EF, 0);
        issue(32'h3C, 0, 4'hF, 32'h0, 32'hCAFEF00D, 0);
        @(posedge clk_i);
        #3 reset_ni = 1'b0;
        #1;
        check("async_rst_rvalid", obi_rvalid_o, 0);
        check("async_rst_errcnt", err_cnt_o, 0);
        sb.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk_i);
        #3 reset_ni = 1'b1;
        obi_rready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        issue(32'h14, 0, 4'hF, 32'h0, 32'h0, 0);
        issue(32'h3C, 0, 4'hF, 32'h0, 32'h0, 0);
        issue(32'h00, 0, 4'hF, 32'h0, 32'h0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
